router_dest_reader: RTL

Destination-side reader for one output port of the 1x3 router. It watches the port's `vld_out_x`, drives the matching `read_enb_x` early enough that the synchronizer's 30-cycle soft-reset timer never expires, and drains one packet: header, payload, then parity. It streams payload bytes to the local client and checks length and parity. Three instances sit at the router's output ports, one per port.

---
 rtl/router_dest_reader.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/router_dest_reader.sv
// router_dest_reader
//   Destination-side reader for one router output port. Sees the port's
//   vld_out, raises read_enb before the router's soft-reset window closes,
//   drains one packet (header, payload, parity), streams the payload bytes
//   to the local client and checks length and parity.
//
//   Packet: header = {len[5:0], addr[1:0]}, len payload bytes, then parity
//   byte = XOR of header and payload.
//
// Parameters
//   DATA_W    byte width (>= 8)
//   READ_DLY  cycles from sampling vld_out=1 to raising read_enb (0..MAX_WAIT-2)
//   MAX_WAIT  router soft-reset window in cycles
//
// Ports
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   vld_out      in   router FIFO not empty
//   data_out     in   router FIFO read data, valid the cycle after a read
//   hold         in   client stall, only defers the start of a read
//   read_enb     out  FIFO read enable
//   rd_byte      out  payload byte
//   rd_byte_vld  out  rd_byte valid this cycle
//   hdr_addr     out  address of current/last packet
//   hdr_len      out  length of current/last packet
//   pkt_done     out  one-cycle pulse on packet completion
//   parity_err   out  one-cycle pulse with pkt_done on parity mismatch
//   trunc_err    out  one-cycle pulse when vld_out drops mid-read
//   timeout      out  one-cycle pulse when the wait window expires
//   busy         out  high whenever the reader is not idle
//
// state   | meaning
// IDLE    | nothing pending, watching vld_out
// WAIT    | data seen, counting the read delay / stalled by hold
// READ    | read_enb issued, capturing header, payload, parity
// BLOCKED | window expired, router is flushing; wait for vld_out low

module router_dest_reader #(
  parameter int DATA_W   = 8,
  parameter int READ_DLY = 2,
  parameter int MAX_WAIT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              hold,
  output logic              read_enb,
  output logic [DATA_W-1:0] rd_byte,
  output logic              rd_byte_vld,
  output logic [1:0]        hdr_addr,
  output logic [5:0]        hdr_len,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              trunc_err,
  output logic              timeout,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(READ_DLY);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_BLOCKED
  } state_t;

  state_t state, state_nxt;

  // dly_cnt / wait_cnt hold the index of the last edge counted since E0,
  // so the edge being evaluated is index cnt+1.
  logic [CNT_W-1:0]  dly_cnt, dly_cnt_nxt, dly_inc;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt, wait_inc;
  logic [6:0]        cap_idx, cap_idx_nxt;
  logic [5:0]        rem, rem_nxt;
  logic [DATA_W-1:0] par, par_nxt, par_upd;
  // data_vld: the FIFO sampled read_enb=1 on the previous edge, so
  // data_out carries a fresh byte this cycle.
  logic              data_vld, data_vld_nxt;

  logic              read_enb_nxt;
  logic [DATA_W-1:0] rd_byte_nxt;
  logic              rd_byte_vld_nxt;
  logic [1:0]        hdr_addr_nxt;
  logic [5:0]        hdr_len_nxt;
  logic              pkt_done_nxt;
  logic              parity_err_nxt;
  logic              trunc_err_nxt;
  logic              timeout_nxt;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    dly_cnt_nxt     = dly_cnt;
    wait_cnt_nxt    = wait_cnt;
    cap_idx_nxt     = cap_idx;
    rem_nxt         = rem;
    par_nxt         = par;
    data_vld_nxt    = 1'b0;
    read_enb_nxt    = 1'b0;
    rd_byte_nxt     = rd_byte;
    rd_byte_vld_nxt = 1'b0;
    hdr_addr_nxt    = hdr_addr;
    hdr_len_nxt     = hdr_len;
    pkt_done_nxt    = 1'b0;
    parity_err_nxt  = 1'b0;
    trunc_err_nxt   = 1'b0;
    timeout_nxt     = 1'b0;

    dly_inc  = (dly_cnt == DLY_LAST) ? dly_cnt : dly_cnt + 1'b1;
    wait_inc = wait_cnt + 1'b1;
    par_upd  = par ^ data_out;

    case (state)
      ST_IDLE: begin
        if (vld_out) begin
          dly_cnt_nxt  = '0;
          wait_cnt_nxt = '0;
          // With no read delay the read can start on E0 itself.
          if ((DLY_LAST == '0) && !hold) begin
            state_nxt    = ST_READ;
            read_enb_nxt = 1'b1;
            cap_idx_nxt  = '0;
            rem_nxt      = '0;
            par_nxt      = '0;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!vld_out) begin
          state_nxt    = ST_IDLE;
          dly_cnt_nxt  = '0;
          wait_cnt_nxt = '0;
        end else if (wait_inc == WAIT_LAST) begin
          // Expiry wins over a read that would start on the same edge:
          // the router's timer is about to fire anyway.
          state_nxt    = ST_BLOCKED;
          timeout_nxt  = 1'b1;
          dly_cnt_nxt  = '0;
          wait_cnt_nxt = '0;
        end else if ((dly_inc == DLY_LAST) && !hold) begin
          state_nxt    = ST_READ;
          read_enb_nxt = 1'b1;
          cap_idx_nxt  = '0;
          rem_nxt      = '0;
          par_nxt      = '0;
          dly_cnt_nxt  = '0;
          wait_cnt_nxt = '0;
        end else begin
          dly_cnt_nxt  = dly_inc;
          wait_cnt_nxt = wait_inc;
        end
      end

      ST_READ: begin
        if (read_enb && !vld_out) begin
          state_nxt     = ST_IDLE;
          trunc_err_nxt = 1'b1;
          cap_idx_nxt   = '0;
          rem_nxt       = '0;
        end else begin
          data_vld_nxt = read_enb;

          // Read-enable length: the header edge already accounts for two
          // FIFO reads (header and this one), so len more remain.
          if (read_enb) begin
            read_enb_nxt = 1'b1;
            if (data_vld) begin
              if (cap_idx == '0) begin
                rem_nxt      = data_out[7:2];
                read_enb_nxt = (data_out[7:2] != 6'd0);
              end else begin
                rem_nxt      = rem - 1'b1;
                read_enb_nxt = (rem != 6'd1);
              end
            end
          end

          if (data_vld) begin
            cap_idx_nxt = cap_idx + 1'b1;
            par_nxt     = par_upd;
            if (cap_idx == '0) begin
              hdr_addr_nxt = data_out[1:0];
              hdr_len_nxt  = data_out[7:2];
            end else if (cap_idx <= {1'b0, hdr_len}) begin
              rd_byte_nxt     = data_out;
              rd_byte_vld_nxt = 1'b1;
            end else begin
              // Parity byte: the running XOR including it must be zero.
              pkt_done_nxt   = 1'b1;
              parity_err_nxt = (par_upd != '0);
              state_nxt      = ST_IDLE;
              cap_idx_nxt    = '0;
            end
          end
        end
      end

      ST_BLOCKED: begin
        if (!vld_out) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dly_cnt     <= '0;
      wait_cnt    <= '0;
      cap_idx     <= '0;
      rem         <= '0;
      par         <= '0;
      data_vld    <= 1'b0;
      read_enb    <= 1'b0;
      rd_byte     <= '0;
      rd_byte_vld <= 1'b0;
      hdr_addr    <= '0;
      hdr_len     <= '0;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      trunc_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      dly_cnt     <= dly_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cap_idx     <= cap_idx_nxt;
      rem         <= rem_nxt;
      par         <= par_nxt;
      data_vld    <= data_vld_nxt;
      read_enb    <= read_enb_nxt;
      rd_byte     <= rd_byte_nxt;
      rd_byte_vld <= rd_byte_vld_nxt;
      hdr_addr    <= hdr_addr_nxt;
      hdr_len     <= hdr_len_nxt;
      pkt_done    <= pkt_done_nxt;
      parity_err  <= parity_err_nxt;
      trunc_err   <= trunc_err_nxt;
      timeout     <= timeout_nxt;
    end
  end

endmodule
